// File: rtl/lea_keypad_scanner_if.sv
// rtl/lea_keypad_scanner_if.sv - keypad matrix and key-event signals of the LEA keypad scanner
interface lea_keypad_scanner_if;
    logic [3:0] row_in;
    logic [2:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       star;
    logic       sharp;

    modport master (
        input  row_in,
        output col_out, key_valid, key_code, star, sharp
    );

    modport slave (
        output row_in,
        input  col_out, key_valid, key_code, star, sharp
    );
endinterface

// File: rtl/lea_keypad_scanner.sv
// rtl/lea_keypad_scanner.sv - 4x3 keypad scanner/debouncer emitting one pulse per press
// Define KEYPAD_SYNC_EN to pass row_in through a 2-flop synchronizer before sampling.
module lea_keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lea_keypad_scanner_if.master  kp
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    state_t         state;
    logic [SW-1:0]  slot_cnt;
    logic [1:0]     col_idx;
    logic [1:0]     col_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic           cnt_reach;
    logic [3:0]     cand;
    logic [1:0]     acc_hits;
    logic [3:0]     acc_code;
    logic [3:0]     row_s;
    logic           slot_last;
    logic           frame_end;

    `ifdef KEYPAD_SYNC_EN
    logic [3:0] row_meta;
    logic [3:0] row_sync;
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= kp.row_in;
            row_sync <= row_meta;
        end
    end
    assign row_s = row_sync;
    `else
    assign row_s = kp.row_in;
    `endif

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        if (r == 2'd3)
            return (c == 2'd0) ? 4'hA : (c == 2'd1) ? 4'h0 : 4'hB;
        return 4'(({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1);
    endfunction

    assign slot_last = (slot_cnt == SW'(SCAN_DIV - 1));
    assign frame_end = slot_last && (col_idx == 2'd2);
    assign col_nxt   = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
    assign cnt_inc   = cnt + CW'(1);
    assign cnt_reach = (cnt_inc >= CW'(DEBOUNCE_FRAMES));

    // Hit count saturates at 2: anything above one low row is simply MULTI.
    logic [1:0] col_hits;
    logic [3:0] col_code;
    logic [1:0] base_hits;
    logic [2:0] hit_sum;
    logic [1:0] frame_hits;
    logic [3:0] frame_code;
    logic       frame_none;
    logic       frame_single;
    logic       frame_match;

    always_comb begin
        col_hits = 2'd0;
        col_code = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) begin
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
                col_code = key_map(2'(r), col_idx);
            end
        end
        base_hits    = (col_idx == 2'd0) ? 2'd0 : acc_hits;
        hit_sum      = {1'b0, base_hits} + {1'b0, col_hits};
        frame_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_code   = (col_hits == 2'd1) ? col_code : acc_code;
        frame_none   = (frame_hits == 2'd0);
        frame_single = (frame_hits == 2'd1);
        frame_match  = frame_single && (frame_code == cand);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt   <= '0;
            col_idx    <= 2'd0;
            kp.col_out <= 3'b110;
            acc_hits   <= 2'd0;
            acc_code   <= 4'h0;
        end else if (slot_last) begin
            slot_cnt   <= '0;
            col_idx    <= col_nxt;
            kp.col_out <= ~(3'b001 << col_nxt);
            acc_hits   <= frame_hits;
            acc_code   <= frame_code;
        end else begin
            slot_cnt   <= slot_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cand         <= 4'h0;
            kp.key_valid <= 1'b0;
            kp.key_code  <= 4'h0;
            kp.star      <= 1'b0;
            kp.sharp     <= 1'b0;
        end else begin
            kp.key_valid <= 1'b0;
            kp.star      <= 1'b0;
            kp.sharp     <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: if (frame_single) begin
                        cand <= frame_code;
                        if (DEBOUNCE_FRAMES <= 1) begin
                            state        <= HELD;
                            cnt          <= '0;
                            kp.key_valid <= 1'b1;
                            kp.key_code  <= frame_code;
                            kp.star      <= (frame_code == 4'hA);
                            kp.sharp     <= (frame_code == 4'hB);
                        end else begin
                            state <= PRESS_DB;
                            cnt   <= CW'(1);
                        end
                    end
                    PRESS_DB: if (frame_match) begin
                        if (cnt_reach) begin
                            state        <= HELD;
                            cnt          <= '0;
                            kp.key_valid <= 1'b1;
                            kp.key_code  <= cand;
                            kp.star      <= (cand == 4'hA);
                            kp.sharp     <= (cand == 4'hB);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                    HELD: if (!frame_match) begin
                        if (frame_none && DEBOUNCE_FRAMES <= 1) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            state <= REL_DB;
                            cnt   <= frame_none ? CW'(1) : '0;
                        end
                    end
                    REL_DB: if (frame_none) begin
                        if (cnt_reach) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else if (frame_match) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= '0;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lea_keypad_scanner.sv
// tb/tb_lea_keypad_scanner.sv - directed-vector bench for lea_keypad_scanner
module tb_lea_keypad_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lea_keypad_scanner_if kif ();

    lea_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    // Keys indexed row*3+col: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
    localparam logic [11:0] K1 = 12'h001, K2 = 12'h002, K3 = 12'h004, K4 = 12'h008;
    localparam logic [11:0] K5 = 12'h010, K7 = 12'h040, K8 = 12'h080, K9 = 12'h100;
    localparam logic [11:0] KSTAR = 12'h200, K0 = 12'h400, KSHARP = 12'h800;

    logic [11:0] keys = '0;

    always_comb begin
        kif.row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !kif.col_out[c]) kif.row_in[r] = 1'b0;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 0;
    int pulses = 0;
    int last_code = 0;
    int last_cyc = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [2:0] exp_col;
        @(negedge clk);
        if (mon_en) begin
            exp_col = ~(3'b001 << ((cyc / 4) % 3));
            chk("col_out", int'(kif.col_out), int'(exp_col));
            if (kif.key_valid) begin
                pulses++;
                last_code = int'(kif.key_code);
                last_cyc  = cyc;
                chk("star_with_valid", int'(kif.star), int'(kif.key_code == 4'hA));
                chk("sharp_with_valid", int'(kif.sharp), int'(kif.key_code == 4'hB));
            end else begin
                chk("no_stray_star_sharp", int'({kif.star, kif.sharp}), 0);
            end
        end
        @(posedge clk);
        cyc = rst ? 0 : cyc + 1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses   = 0;
        last_cyc = -1;
    endtask

    task automatic run(input logic [11:0] k, input int n);
        keys = k;
        repeat (12 * n) tick();
    endtask

    typedef struct {
        logic [11:0] keys;
        int          frames;
        int          exp_pulses;
        int          exp_code;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{12'h000, 3, 0, 0, 0};
        vecs[1] = '{K5, 10, 1, 5, 36};
        vecs[2] = '{KSTAR, 5, 1, 10, 36};
        vecs[3] = '{KSHARP, 5, 1, 11, 36};
        vecs[4] = '{K1 | K2, 6, 0, 0, 0};
        vecs[5] = '{K1 | K4, 6, 0, 0, 0};
        vecs[6] = '{K0, 3, 1, 0, 36};
        vecs[7] = '{K9, 2, 0, 0, 0};
        vecs[8] = '{K3, 3, 1, 3, 36};

        keys = '0;
        do_reset();
        mon_en = 1;
        chk("reset_col_out", int'(kif.col_out), 6);
        chk("reset_key_valid", int'(kif.key_valid), 0);
        chk("reset_key_code", int'(kif.key_code), 0);

        for (int i = 0; i < 9; i++) begin
            keys = '0;
            do_reset();
            run(vecs[i].keys, vecs[i].frames);
            run('0, 1);
            chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
            chk($sformatf("vec%0d_key_code", i), int'(kif.key_code), vecs[i].exp_code);
            if (vecs[i].exp_pulses > 0) begin
                chk($sformatf("vec%0d_code", i), last_code, vecs[i].exp_code);
                chk($sformatf("vec%0d_latency", i), last_cyc, vecs[i].exp_cyc);
            end
        end

        // '#' bounce: 2 frames on, 1 off, 3 on
        keys = '0;
        do_reset();
        run(KSHARP, 2);
        run('0, 1);
        run(KSHARP, 3);
        run('0, 1);
        chk("bounce_pulses", pulses, 1);
        chk("bounce_cycle", last_cyc, 72);
        chk("bounce_code", last_code, 11);

        // '7' partial release does not re-report; full release does
        keys = '0;
        do_reset();
        run(K7, 3);
        run('0, 2);
        run(K7, 3);
        chk("partial_release_pulses", pulses, 1);
        run('0, 3);
        run(K7, 3);
        run('0, 1);
        chk("full_release_pulses", pulses, 2);
        chk("full_release_cycle", last_cyc, 168);

        // Key change while held needs a full release
        keys = '0;
        do_reset();
        run(K7, 3);
        run(K8, 4);
        chk("change_held_pulses", pulses, 1);
        chk("change_held_code", int'(kif.key_code), 7);
        run('0, 3);
        run(K8, 3);
        run('0, 1);
        chk("change_after_release_pulses", pulses, 2);
        chk("change_after_release_code", last_code, 8);
        chk("change_after_release_cycle", last_cyc, 156);

        // Reset during PRESS_DB with '9' held
        keys = '0;
        do_reset();
        keys = K9;
        repeat (18) tick();
        chk("pre_rst_pulses", pulses, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_col_out", int'(kif.col_out), 6);
        chk("mid_rst_key_valid", int'(kif.key_valid), 0);
        run(K9, 3);
        run('0, 1);
        chk("post_rst_pulses", pulses, 1);
        chk("post_rst_code", last_code, 9);
        chk("post_rst_cycle", last_cyc, 36);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
